bidir_bounce_counter: RTL and testbench

Parametrised up/down counter with programmable bounds. It has four modes:
- bounce (ping-pong between bounds)
- up-wrap
- down-wrap
- hold

It also provides synchronous load, bound flags, a bound-hit pulse and a period counter. It is the general counting/sequencing primitive for display scanning, LED chasers and timing sub-blocks, and replaces the fixed 3-bit ping-pong counter.

---
 rtl/bidir_bounce_counter.sv | 148 ++++++++++++++
 tb/tb_bidir_bounce_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bidir_bounce_counter.sv
// Up/down counter with programmable bounds: bounce, up-wrap, down-wrap and hold modes.
// Define PRESCALE_EN to add a divider so that a step needs PRESCALE enabled cycles.
module bidir_bounce_counter #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned LO       = 0,
  parameter int unsigned HI       = 7,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             at_lo,
  output logic             at_hi,
  output logic             turn,
  output logic [7:0]       periods
);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("bidir_bounce_counter: WIDTH must be in 2..16");
  end
  if (LO >= HI) begin : g_bad_bounds
    $error("bidir_bounce_counter: LO must be below HI");
  end
  if ((HI >> WIDTH) != 0) begin : g_bad_hi
    $error("bidir_bounce_counter: HI does not fit in WIDTH bits");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("bidir_bounce_counter: PRESCALE must be in 1..65535");
  end

  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    if (v < LO_V) return LO_V;
    if (v > HI_V) return HI_V;
    return v;
  endfunction

  // Direction follows the new count so bounce sits on a bound already pointing away.
  function automatic logic dir_rule(input mode_e m, input logic [WIDTH-1:0] c, input logic d);
    if (m == MODE_UP)   return 1'b0;
    if (m == MODE_DOWN) return 1'b1;
    if (c == HI_V)      return 1'b1;
    if (c == LO_V)      return 1'b0;
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] step_val(input mode_e m, input logic [WIDTH-1:0] c,
                                               input logic d);
    case (m)
      MODE_BOUNCE: begin
        if (!d) return (c == HI_V) ? c - ONE : c + ONE;
        return (c == LO_V) ? c + ONE : c - ONE;
      end
      MODE_UP:   return (c == HI_V) ? LO_V : c + ONE;
      MODE_DOWN: return (c == LO_V) ? HI_V : c - ONE;
      default:   return c;
    endcase
  endfunction

  mode_e            mode_s;
  logic [WIDTH-1:0] count_d;
  logic             dir_d;
  logic             turn_d;
  logic [7:0]       periods_d;
  logic             step;

`ifdef PRESCALE_EN
  localparam logic [15:0] DIV_LAST = 16'(PRESCALE - 1);
  logic [15:0] div_q;
  logic [15:0] div_d;
`endif

  assign mode_s = mode_e'(mode);
  assign at_lo  = (count == LO_V);
  assign at_hi  = (count == HI_V);

  // Next-state: load beats step beats idle.
  always_comb begin
    count_d   = count;
    dir_d     = dir;
    turn_d    = 1'b0;
    periods_d = periods;
    step      = 1'b0;
`ifdef PRESCALE_EN
    div_d     = div_q;
`endif
    if (load) begin
      count_d = clamp(load_val);
      dir_d   = dir_rule(mode_s, count_d, dir);
`ifdef PRESCALE_EN
      div_d   = 16'd0;
`endif
    end else if (en && mode_s != MODE_HOLD) begin
`ifdef PRESCALE_EN
      if (div_q == DIV_LAST) begin
        step  = 1'b1;
        div_d = 16'd0;
      end else begin
        div_d = div_q + 16'd1;
      end
`else
      step = 1'b1;
`endif
      if (step) begin
        count_d = step_val(mode_s, count, dir);
        dir_d   = dir_rule(mode_s, count_d, dir);
        turn_d  = (count_d == LO_V) || (count_d == HI_V);
        if (count_d == LO_V) periods_d = periods + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= LO_V;
      dir     <= 1'b0;
      turn    <= 1'b0;
      periods <= 8'd0;
`ifdef PRESCALE_EN
      div_q   <= 16'd0;
`endif
    end else begin
      count   <= count_d;
      dir     <= dir_d;
      turn    <= turn_d;
      periods <= periods_d;
`ifdef PRESCALE_EN
      div_q   <= div_d;
`endif
    end
  end

endmodule

// File: tb/tb_bidir_bounce_counter.sv
// Directed bench for bidir_bounce_counter: three instances cover full range, narrow
// bounds with clamped loads, and a PRESCALE=3 instance on its own reset.
module tb_bidir_bounce_counter;

  logic clk = 1'b0;
  logic reset_n;
  logic rst_c;
  always #5 clk = ~clk;

  logic       a_en, a_load, a_dir, a_at_lo, a_at_hi, a_turn;
  logic [1:0] a_mode;
  logic [2:0] a_lv, a_count;
  logic [7:0] a_periods;

  logic       b_en, b_load, b_dir, b_at_lo, b_at_hi, b_turn;
  logic [1:0] b_mode;
  logic [3:0] b_lv, b_count;
  logic [7:0] b_periods;

  logic       c_en, c_load, c_dir, c_at_lo, c_at_hi, c_turn;
  logic [1:0] c_mode;
  logic [2:0] c_lv, c_count;
  logic [7:0] c_periods;

  bidir_bounce_counter #(.WIDTH(3), .LO(0), .HI(7), .PRESCALE(1)) u_a (
    .clk(clk), .reset_n(reset_n), .en(a_en), .mode(a_mode), .load(a_load),
    .load_val(a_lv), .count(a_count), .dir(a_dir), .at_lo(a_at_lo), .at_hi(a_at_hi),
    .turn(a_turn), .periods(a_periods));

  bidir_bounce_counter #(.WIDTH(4), .LO(2), .HI(5), .PRESCALE(1)) u_b (
    .clk(clk), .reset_n(reset_n), .en(b_en), .mode(b_mode), .load(b_load),
    .load_val(b_lv), .count(b_count), .dir(b_dir), .at_lo(b_at_lo), .at_hi(b_at_hi),
    .turn(b_turn), .periods(b_periods));

  bidir_bounce_counter #(.WIDTH(3), .LO(0), .HI(7), .PRESCALE(3)) u_c (
    .clk(clk), .reset_n(rst_c), .en(c_en), .mode(c_mode), .load(c_load),
    .load_val(c_lv), .count(c_count), .dir(c_dir), .at_lo(c_at_lo), .at_hi(c_at_hi),
    .turn(c_turn), .periods(c_periods));

  int total = 0;
  int bad   = 0;

  int t1_cnt  [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int t1_dir  [15] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int t1_turn [15] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
  int t2_cnt  [6]  = '{3, 4, 5, 2, 3, 4};
  int t2_turn [6]  = '{0, 0, 1, 1, 0, 0};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; rst_c = 1'b0;
    a_en = 0; a_mode = 2'b00; a_load = 0; a_lv = '0;
    b_en = 0; b_mode = 2'b00; b_load = 0; b_lv = '0;
    c_en = 0; c_mode = 2'b00; c_load = 0; c_lv = '0;
    repeat (2) tick();
    reset_n = 1'b1; rst_c = 1'b1;

    check("a_rst_count", 16'(a_count), 16'd0);
    check("a_rst_dir", 16'(a_dir), 16'd0);
    check("a_rst_turn", 16'(a_turn), 16'd0);
    check("a_rst_periods", 16'(a_periods), 16'd0);
    check("a_rst_at_lo", 16'(a_at_lo), 16'd1);
    check("a_rst_at_hi", 16'(a_at_hi), 16'd0);
    check("b_rst_count", 16'(b_count), 16'd2);
    check("b_rst_at_lo", 16'(b_at_lo), 16'd1);

    // Full-range bounce
    a_en = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("t1_count[%0d]", i), 16'(a_count), 16'(t1_cnt[i]));
      check($sformatf("t1_dir[%0d]", i), 16'(a_dir), 16'(t1_dir[i]));
      check($sformatf("t1_turn[%0d]", i), 16'(a_turn), 16'(t1_turn[i]));
    end
    check("t1_periods", 16'(a_periods), 16'd1);

    // Pause and hold while descending at 4
    repeat (9) tick();
    check("t5_count_start", 16'(a_count), 16'd4);
    check("t5_dir_start", 16'(a_dir), 16'd1);
    a_en = 0;
    repeat (3) tick();
    check("t5_en0_count", 16'(a_count), 16'd4);
    check("t5_en0_turn", 16'(a_turn), 16'd0);
    a_en = 1; a_mode = 2'b11;
    repeat (2) tick();
    check("t5_hold_count", 16'(a_count), 16'd4);
    check("t5_hold_dir", 16'(a_dir), 16'd1);
    check("t5_hold_turn", 16'(a_turn), 16'd0);
    a_mode = 2'b00;
    tick();
    check("t5_resume_count", 16'(a_count), 16'd3);
    check("t5_periods", 16'(a_periods), 16'd1);
    a_en = 0;

    // Down-wrap from reset on LO=2, HI=5
    b_en = 1; b_mode = 2'b10;
    tick();
    check("t3_count0", 16'(b_count), 16'd5);
    check("t3_dir0", 16'(b_dir), 16'd1);
    check("t3_turn0", 16'(b_turn), 16'd1);
    check("t3_at_hi0", 16'(b_at_hi), 16'd1);
    check("t3_periods0", 16'(b_periods), 16'd0);
    tick();
    check("t3_count1", 16'(b_count), 16'd4);
    check("t3_turn1", 16'(b_turn), 16'd0);
    tick();
    check("t3_count2", 16'(b_count), 16'd3);
    check("t3_periods2", 16'(b_periods), 16'd0);
    tick();
    check("t3_count3", 16'(b_count), 16'd2);
    check("t3_turn3", 16'(b_turn), 16'd1);
    check("t3_dir3", 16'(b_dir), 16'd1);
    check("t3_periods3", 16'(b_periods), 16'd1);

    // Up-wrap
    b_mode = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t2_count[%0d]", i), 16'(b_count), 16'(t2_cnt[i]));
      check($sformatf("t2_dir[%0d]", i), 16'(b_dir), 16'd0);
      check($sformatf("t2_turn[%0d]", i), 16'(b_turn), 16'(t2_turn[i]));
    end
    check("t2_periods", 16'(b_periods), 16'd2);

    // Clamped loads, with and without en, and in hold
    b_mode = 2'b00; b_load = 1; b_lv = 4'd9;
    tick();
    check("t4_load_hi_count", 16'(b_count), 16'd5);
    check("t4_load_hi_dir", 16'(b_dir), 16'd1);
    check("t4_load_hi_turn", 16'(b_turn), 16'd0);
    b_load = 0;
    tick();
    check("t4_after_load_count", 16'(b_count), 16'd4);
    check("t4_after_load_dir", 16'(b_dir), 16'd1);
    b_load = 1; b_lv = 4'd0;
    tick();
    check("t4_load_lo_count", 16'(b_count), 16'd2);
    check("t4_load_lo_dir", 16'(b_dir), 16'd0);
    check("t4_load_lo_turn", 16'(b_turn), 16'd0);
    check("t4_load_lo_periods", 16'(b_periods), 16'd2);
    b_load = 0;
    tick();
    check("t4_step_count", 16'(b_count), 16'd3);
    b_mode = 2'b11; b_load = 1; b_lv = 4'd4;
    tick();
    check("t4_hold_load_count", 16'(b_count), 16'd4);
    check("t4_hold_load_dir", 16'(b_dir), 16'd0);
    b_load = 0;
    tick();
    check("t4_hold_count", 16'(b_count), 16'd4);
    check("t4_hold_turn", 16'(b_turn), 16'd0);
    b_en = 0;

    // Prescaled instance with a reset in the middle of a divide period
    c_en = 1;
`ifdef PRESCALE_EN
    repeat (2) tick();
    check("t6_div_wait", 16'(c_count), 16'd0);
    tick();
    check("t6_first_step", 16'(c_count), 16'd1);
    repeat (3) tick();
    check("t6_second_step", 16'(c_count), 16'd2);
    repeat (2) tick();
    check("t6_mid_div", 16'(c_count), 16'd2);
    rst_c = 1'b0;
    #1;
    check("t6_rst_count", 16'(c_count), 16'd0);
    check("t6_rst_at_lo", 16'(c_at_lo), 16'd1);
    rst_c = 1'b1;
    repeat (2) tick();
    check("t6_rel_wait", 16'(c_count), 16'd0);
    tick();
    check("t6_rel_step", 16'(c_count), 16'd1);
`else
    tick();
    check("t6_no_div_step", 16'(c_count), 16'd1);
    repeat (2) tick();
    check("t6_no_div_step3", 16'(c_count), 16'd3);
    rst_c = 1'b0;
    #1;
    check("t6_rst_count", 16'(c_count), 16'd0);
    check("t6_rst_at_lo", 16'(c_at_lo), 16'd1);
    rst_c = 1'b1;
    tick();
    check("t6_rel_step", 16'(c_count), 16'd1);
`endif
    c_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
